// File: rtl/execute_stage_if.sv
// Bundles the E-stage operand/control inputs and the execute results.
// Purely structural; no storage or timing of its own.
// The slave modport belongs to execute_stage; the master modport drives the E stage.
interface execute_stage_if;
  logic        e_valid;
  logic [3:0]  e_icode;
  logic [3:0]  e_ifun;
  logic [63:0] e_valA;
  logic [63:0] e_valB;
  logic [63:0] e_valC;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;
  logic        m_stall;
  logic        m_bubble;
  logic        cc_hold;

  logic [63:0] e_valE;
  logic        e_Cnd;
  logic [3:0]  e_dstE_fwd;
  logic        M_valid;
  logic        M_Cnd;
  logic [3:0]  M_icode;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        cc_zf;
  logic        cc_sf;
  logic        cc_of;

  modport slave (
    input  e_valid, e_icode, e_ifun, e_valA, e_valB, e_valC, e_dstE, e_dstM,
           m_stall, m_bubble, cc_hold,
    output e_valE, e_Cnd, e_dstE_fwd, M_valid, M_Cnd, M_icode, M_valE, M_valA,
           M_dstE, M_dstM, cc_zf, cc_sf, cc_of
  );

  modport master (
    output e_valid, e_icode, e_ifun, e_valA, e_valB, e_valC, e_dstE, e_dstM,
           m_stall, m_bubble, cc_hold,
    input  e_valE, e_Cnd, e_dstE_fwd, M_valid, M_Cnd, M_icode, M_valE, M_valA,
           M_dstE, M_dstM, cc_zf, cc_sf, cc_of
  );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov condition and the E->M pipeline register.
// e_valE/e_Cnd/e_dstE_fwd are combinational; M outputs are one cycle after the E inputs.
// m_stall freezes the M register and CC; m_bubble or an empty E stage loads a nop.
module execute_stage (
  input logic clk,
  input logic rst,
  execute_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } m_reg_t;

  localparam m_reg_t M_NOP = '{valid: 1'b0, icode: 4'h1, cnd: 1'b0, val_e: 64'd0,
                               val_a: 64'd0, dst_e: 4'hF, dst_m: 4'hF};

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [1:0]  alu_fun;
  logic [63:0] alu_res;
  logic        alu_of;
  logic        cnd;
  logic        cc_load;
  logic        zf_q, sf_q, of_q;
  m_reg_t      m_q;
  m_reg_t      m_load;

  // Operand and function selection from the instruction code; unused icodes add 0+0.
  always_comb begin
    alu_a = 64'd0;
    alu_b = 64'd0;
    case (bus.e_icode)
      4'h2, 4'h6:       alu_a = bus.e_valA;
      4'h3, 4'h4, 4'h5: alu_a = bus.e_valC;
      4'h8, 4'hA:       alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      4'h9, 4'hB:       alu_a = 64'd8;
      default:          alu_a = 64'd0;
    endcase
    case (bus.e_icode)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_b = bus.e_valB;
      default:                                   alu_b = 64'd0;
    endcase
    alu_fun = (bus.e_icode == 4'h6) ? bus.e_ifun[1:0] : ALU_ADD;
  end

  // ALU with signed-overflow detection for add and subtract (operands ordered B op A).
  always_comb begin
    alu_res = 64'd0;
    alu_of  = 1'b0;
    case (alu_fun)
      ALU_ADD: begin
        alu_res = alu_b + alu_a;
        alu_of  = (alu_a[63] == alu_b[63]) && (alu_res[63] != alu_b[63]);
      end
      ALU_SUB: begin
        alu_res = alu_b - alu_a;
        alu_of  = (alu_a[63] != alu_b[63]) && (alu_res[63] != alu_b[63]);
      end
      ALU_AND: alu_res = alu_b & alu_a;
      default: alu_res = alu_b ^ alu_a;
    endcase
  end

  // Condition evaluated against the CC value held before this instruction's update.
  always_comb begin
    cnd = 1'b0;
    case (bus.e_ifun)
      4'h0:    cnd = 1'b1;
      4'h1:    cnd = (sf_q ^ of_q) | zf_q;
      4'h2:    cnd = sf_q ^ of_q;
      4'h3:    cnd = zf_q;
      4'h4:    cnd = ~zf_q;
      4'h5:    cnd = ~(sf_q ^ of_q);
      4'h6:    cnd = ~(sf_q ^ of_q) & ~zf_q;
      default: cnd = 1'b0;
    endcase
  end

  assign cc_load = bus.e_valid && (bus.e_icode == 4'h6) && !bus.cc_hold && !bus.m_stall;

  // Condition-code register: reset to ZF=1, otherwise loaded only by a live OPq.
  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (cc_load) begin
      zf_q <= (alu_res == 64'd0);
      sf_q <= alu_res[63];
      of_q <= alu_of;
    end
  end

  // Value captured into M when the stage advances normally.
  always_comb begin
    m_load       = M_NOP;
    m_load.valid = 1'b1;
    m_load.icode = bus.e_icode;
    m_load.cnd   = cnd;
    m_load.val_e = alu_res;
    m_load.val_a = bus.e_valA;
    m_load.dst_e = bus.e_dstE_fwd;
    m_load.dst_m = bus.e_dstM;
  end

  // E->M register: reset beats stall, stall beats bubble, bubble/empty E loads a nop.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= M_NOP;
    end else if (bus.m_stall) begin
      m_q <= m_q;
    end else if (bus.m_bubble || !bus.e_valid) begin
      m_q <= M_NOP;
    end else begin
      m_q <= m_load;
    end
  end

  assign bus.e_valE     = alu_res;
  assign bus.e_Cnd      = cnd;
  assign bus.e_dstE_fwd = ((bus.e_icode == 4'h2) && !cnd) ? 4'hF : bus.e_dstE;
  assign bus.M_valid    = m_q.valid;
  assign bus.M_Cnd      = m_q.cnd;
  assign bus.M_icode    = m_q.icode;
  assign bus.M_valE     = m_q.val_e;
  assign bus.M_valA     = m_q.val_a;
  assign bus.M_dstE     = m_q.dst_e;
  assign bus.M_dstM     = m_q.dst_m;
  assign bus.cc_zf      = zf_q;
  assign bus.cc_sf      = sf_q;
  assign bus.cc_of      = of_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed test of execute_stage: ALU ops, CC/condition logic, cmov squash, stack ops, stall/bubble/reset.
// Comb outputs are sampled 1 time unit after inputs change; registered outputs 1 unit after the edge.
// Exercises stall, stall+bubble, bubble alone, empty E stage and reset overriding stall.
module tb_execute_stage;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  execute_stage_if bus ();

  execute_stage dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                       input logic [3:0] de, input logic [3:0] dm);
    bus.e_valid = 1'b1;
    bus.e_icode = icode;
    bus.e_ifun  = ifun;
    bus.e_valA  = va;
    bus.e_valB  = vb;
    bus.e_valC  = vc;
    bus.e_dstE  = de;
    bus.e_dstM  = dm;
    #1;
  endtask

  function automatic logic [63:0] cc3();
    return {61'd0, bus.cc_zf, bus.cc_sf, bus.cc_of};
  endfunction

  initial begin
    rst          = 1'b1;
    bus.e_valid  = 1'b0;
    bus.e_icode  = 4'h1;
    bus.e_ifun   = 4'h0;
    bus.e_valA   = '0;
    bus.e_valB   = '0;
    bus.e_valC   = '0;
    bus.e_dstE   = 4'hF;
    bus.e_dstM   = 4'hF;
    bus.m_stall  = 1'b0;
    bus.m_bubble = 1'b0;
    bus.cc_hold  = 1'b0;

    // Reset state
    step();
    rst = 1'b0;
    chk("rst_M_valid", bus.M_valid, 0);
    chk("rst_M_icode", bus.M_icode, 4'h1);
    chk("rst_M_dstE", bus.M_dstE, 4'hF);
    chk("rst_M_dstM", bus.M_dstM, 4'hF);
    chk("rst_M_valE", bus.M_valE, 0);
    chk("rst_cc", cc3(), 3'b100);

    // addq overflow into sign bit
    set_e(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 4'h2, 4'hF);
    chk("add_ovf_comb_valE", bus.e_valE, 64'h8000_0000_0000_0000);
    step();
    chk("add_ovf_M_valE", bus.M_valE, 64'h8000_0000_0000_0000);
    chk("add_ovf_M_valid", bus.M_valid, 1);
    chk("add_ovf_M_icode", bus.M_icode, 4'h6);
    chk("add_ovf_M_dstE", bus.M_dstE, 4'h2);
    chk("add_ovf_cc", cc3(), 3'b011);

    // subq to zero, then je / jne
    set_e(4'h6, 4'h1, 64'd5, 64'd5, 0, 4'h4, 4'hF);
    chk("sub_zero_comb", bus.e_valE, 0);
    step();
    chk("sub_zero_cc", cc3(), 3'b100);
    set_e(4'h7, 4'h3, 0, 0, 64'h40, 4'hF, 4'hF);
    chk("je_comb_cnd", bus.e_Cnd, 1);
    step();
    chk("je_M_Cnd", bus.M_Cnd, 1);
    set_e(4'h7, 4'h4, 0, 0, 64'h40, 4'hF, 4'hF);
    step();
    chk("jne_M_Cnd", bus.M_Cnd, 0);
    chk("jmp_keeps_cc", cc3(), 3'b100);

    // CC=000, then cmovl squashed and rrmovq taken
    set_e(4'h6, 4'h0, 64'd1, 64'd1, 0, 4'h1, 4'hF);
    step();
    chk("add_pos_cc", cc3(), 3'b000);
    set_e(4'h2, 4'h2, 64'h1234, 0, 0, 4'h3, 4'hF);
    chk("cmovl_comb_cnd", bus.e_Cnd, 0);
    chk("cmovl_comb_dstE", bus.e_dstE_fwd, 4'hF);
    step();
    chk("cmovl_M_dstE", bus.M_dstE, 4'hF);
    set_e(4'h2, 4'h0, 64'hABCD, 0, 0, 4'h3, 4'hF);
    step();
    chk("rrmov_M_dstE", bus.M_dstE, 4'h3);
    chk("rrmov_M_valE", bus.M_valE, 64'hABCD);

    // Stack pointer and address arithmetic
    set_e(4'hA, 4'h0, 64'h55, 64'h100, 0, 4'h4, 4'hF);
    step();
    chk("pushq_valE", bus.M_valE, 64'hF8);
    chk("pushq_valA", bus.M_valA, 64'h55);
    set_e(4'hB, 4'h0, 64'h100, 64'h100, 0, 4'h4, 4'h5);
    step();
    chk("popq_valE", bus.M_valE, 64'h108);
    chk("popq_dstM", bus.M_dstM, 4'h5);
    set_e(4'h8, 4'h0, 0, 64'h100, 64'h200, 4'h4, 4'hF);
    step();
    chk("call_valE", bus.M_valE, 64'hF8);
    set_e(4'h5, 4'h0, 0, 64'h100, 64'h10, 4'hF, 4'h6);
    step();
    chk("mrmovq_valE", bus.M_valE, 64'h110);

    // and / xor / subtract overflow, then condition variants
    set_e(4'h6, 4'h2, 64'hF0, 64'h3C, 0, 4'h1, 4'hF);
    chk("and_comb", bus.e_valE, 64'h30);
    step();
    chk("and_cc", cc3(), 3'b000);
    set_e(4'h6, 4'h3, 64'h77, 64'h77, 0, 4'h1, 4'hF);
    step();
    chk("xor_valE", bus.M_valE, 0);
    chk("xor_cc", cc3(), 3'b100);
    set_e(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 0, 4'h1, 4'hF);
    chk("sub_ovf_comb", bus.e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
    step();
    chk("sub_ovf_cc", cc3(), 3'b001);
    set_e(4'h7, 4'h1, 0, 0, 0, 4'hF, 4'hF);
    chk("jle_cnd", bus.e_Cnd, 1);
    set_e(4'h7, 4'h6, 0, 0, 0, 4'hF, 4'hF);
    chk("jg_cnd", bus.e_Cnd, 0);
    set_e(4'h7, 4'h5, 0, 0, 0, 4'hF, 4'hF);
    chk("jge_cnd", bus.e_Cnd, 0);
    set_e(4'h7, 4'h9, 0, 0, 0, 4'hF, 4'hF);
    chk("ifun9_cnd", bus.e_Cnd, 0);

    // cc_hold blocks update; invalid and halt produce zero with no CC change
    bus.cc_hold = 1'b1;
    set_e(4'h6, 4'h0, 0, 0, 0, 4'h1, 4'hF);
    step();
    bus.cc_hold = 1'b0;
    chk("cc_hold_cc", cc3(), 3'b001);
    set_e(4'hC, 4'h0, 64'd5, 64'd6, 64'd7, 4'h1, 4'hF);
    chk("invalid_valE", bus.e_valE, 0);
    step();
    chk("invalid_cc", cc3(), 3'b001);
    set_e(4'h0, 4'h0, 64'd5, 64'd6, 64'd7, 4'h1, 4'hF);
    chk("halt_valE", bus.e_valE, 0);

    // Stall holds M and CC, stall+bubble holds, bubble alone loads nop
    set_e(4'h6, 4'h0, 64'd2, 64'd3, 0, 4'h2, 4'h7);
    step();
    chk("pre_stall_valE", bus.M_valE, 64'd5);
    chk("pre_stall_cc", cc3(), 3'b000);
    bus.m_stall = 1'b1;
    set_e(4'h6, 4'h1, 64'd9, 64'd9, 0, 4'h7, 4'hF);
    step();
    step();
    chk("stall_valE", bus.M_valE, 64'd5);
    chk("stall_dstE", bus.M_dstE, 4'h2);
    chk("stall_dstM", bus.M_dstM, 4'h7);
    chk("stall_cc", cc3(), 3'b000);
    bus.m_bubble = 1'b1;
    step();
    chk("stall_bubble_valE", bus.M_valE, 64'd5);
    chk("stall_bubble_valid", bus.M_valid, 1);
    bus.m_stall = 1'b0;
    step();
    bus.m_bubble = 1'b0;
    chk("bubble_valid", bus.M_valid, 0);
    chk("bubble_icode", bus.M_icode, 4'h1);
    chk("bubble_valE", bus.M_valE, 0);
    chk("bubble_dstE", bus.M_dstE, 4'hF);
    chk("bubble_cc_upd", cc3(), 3'b100);

    // Empty E stage loads nop
    set_e(4'h6, 4'h0, 64'd1, 64'd1, 0, 4'h2, 4'hF);
    step();
    chk("load_again_valid", bus.M_valid, 1);
    bus.e_valid = 1'b0;
    step();
    chk("empty_valid", bus.M_valid, 0);
    chk("empty_dstM", bus.M_dstM, 4'hF);

    // Reset overrides stall and CC update
    set_e(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 4'h2, 4'hF);
    step();
    chk("pre_rst_cc", cc3(), 3'b011);
    rst = 1'b1;
    bus.m_stall = 1'b1;
    set_e(4'h6, 4'h0, 64'd1, 64'd1, 0, 4'h2, 4'hF);
    step();
    chk("rst_over_stall_valid", bus.M_valid, 0);
    chk("rst_over_stall_icode", bus.M_icode, 4'h1);
    chk("rst_over_stall_cc", cc3(), 3'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
